core_sched: RTL

Round-robin scheduler for the CPU7 core array. It owns the shared program-memory read port and the shared dispatch bus (push value / instruction pair / pcp step). It selects one eligible core at a time, fetches code words at that core's `pcp`, and dispatches them. It waits for the core to report idle before the next word. It sits between the program ROM/RAM and the `CORES` instances of the core module.

---
 rtl/cpu7_sched_pkg.sv | 28 ++
 rtl/core_sched_rr_pick.sv | 27 ++
 rtl/core_sched.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu7_sched_pkg.sv
// Shared definitions for the CPU7 core scheduler: FSM states, code-word types
// and datapath widths.
package cpu7_sched_pkg;

    typedef enum logic [2:0] {
        S_SELECT,
        S_FETCH,
        S_DATA,
        S_DISPATCH,
        S_GUARD,
        S_WAIT
    } sched_state_t;

    localparam logic [1:0] W_INSTR = 2'b00;
    localparam logic [1:0] W_LIT   = 2'b01;
    localparam logic [1:0] W_YIELD = 2'b10;
    localparam logic [1:0] W_RSVD  = 2'b11;

    localparam int LIT_W  = 14;
    localparam int PUSH_W = 56;
    localparam int PCP_W  = 28;
    localparam int WORD_W = 16;

    function automatic logic [PUSH_W-1:0] lit_extend(input logic [LIT_W-1:0] lit);
        return {{(PUSH_W-LIT_W){1'b0}}, lit};
    endfunction

endpackage

// File: rtl/core_sched_rr_pick.sv
// Combinational round-robin finder: first set request above 'last', wrapping
// around, with a valid flag when any request is set.
module rr_pick #(
    parameter  int CORES = 4,
    localparam int IW    = (CORES > 1) ? $clog2(CORES) : 1
) (
    input  logic [CORES-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [IW-1:0]    next_idx,
    output logic             valid
);

    always_comb begin
        logic [IW-1:0] idx;
        next_idx = last;
        valid    = 1'b0;
        idx      = last;
        for (int k = 0; k < CORES; k++) begin
            idx = (idx == IW'(CORES-1)) ? '0 : idx + 1'b1;
            if (!valid && req[idx]) begin
                next_idx = idx;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_sched.sv
// Round-robin fetch/dispatch scheduler for the CPU7 core array.
// Optional watchdog on the idle wait is enabled by defining CORE_SCHED_WATCHDOG_EN.
module core_sched
    import cpu7_sched_pkg::*;
#(
    parameter  int CORES   = 4,
    parameter  int QUANTUM = 8,
    localparam int IW      = (CORES > 1) ? $clog2(CORES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic [CORES*28-1:0]   core_pcp,
    input  logic [CORES-1:0]      core_executing,
    input  logic [CORES-1:0]      core_idle,
    output logic [CORES-1:0]      core_en,
    output logic [27:0]           mem_addr,
    output logic                  mem_rd,
    input  logic [15:0]           mem_data,
    output logic [55:0]           push_value,
    output logic                  push_en,
    output logic [13:0]           instr,
    output logic                  instr_en,
    output logic                  pcp_step_en,
    output logic [IW-1:0]         cur_core,
    output logic                  busy,
    output logic                  fault
);

    localparam int QW = $clog2(QUANTUM + 1);

    sched_state_t        state_reg, state_next;
    logic [IW-1:0]       cur_reg, cur_next;
    logic [CORES-1:0]    en_reg, en_next;
    logic [QW-1:0]       qcnt_reg, qcnt_next;
    logic                mem_rd_reg, mem_rd_next;
    logic                push_en_reg, push_en_next;
    logic                instr_en_reg, instr_en_next;
    logic                step_reg, step_next;
    logic                yield_reg, yield_next;
    logic [PUSH_W-1:0]   push_value_reg, push_value_next;
    logic [LIT_W-1:0]    instr_reg, instr_next;

    logic [PCP_W-1:0]    pcp_arr [CORES];
    logic [CORES-1:0]    eligible;
    logic [CORES-1:0]    pick_onehot;
    logic [IW-1:0]       pick_idx;
    logic                pick_valid;
    logic                cur_idle;
    logic                cur_exec;
    logic                quantum_done;
    logic                wd_timeout;

    for (genvar gi = 0; gi < CORES; gi++) begin : g_core
        assign pcp_arr[gi]     = core_pcp[PCP_W*gi +: PCP_W];
        assign pick_onehot[gi] = (pick_idx == IW'(gi));
    end

    assign eligible     = {CORES{run}} & core_executing;
    assign cur_idle     = core_idle[cur_reg];
    assign cur_exec     = core_executing[cur_reg];
    assign quantum_done = (qcnt_reg >= QW'(QUANTUM));

    rr_pick #(.CORES(CORES)) u_rr_pick (
        .req      (eligible),
        .last     (cur_reg),
        .next_idx (pick_idx),
        .valid    (pick_valid)
    );

`ifdef CORE_SCHED_WATCHDOG_EN
    logic [5:0] wd_reg, wd_next;
    logic       fault_reg, fault_next;

    // Counts consecutive non-idle cycles in S_WAIT; the 63rd one trips.
    always_comb begin
        wd_timeout = (state_reg == S_WAIT) && !cur_idle && (wd_reg == 6'd62);
        wd_next    = ((state_reg == S_WAIT) && !cur_idle) ? wd_reg + 6'd1 : 6'd0;
        fault_next = fault_reg | wd_timeout;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_reg    <= '0;
            fault_reg <= 1'b0;
        end else begin
            wd_reg    <= wd_next;
            fault_reg <= fault_next;
        end
    end

    assign fault = fault_reg;
`else
    assign wd_timeout = 1'b0;
    assign fault      = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        cur_next        = cur_reg;
        en_next         = en_reg;
        qcnt_next       = qcnt_reg;
        mem_rd_next     = 1'b0;
        push_en_next    = 1'b0;
        instr_en_next   = 1'b0;
        step_next       = 1'b0;
        yield_next      = yield_reg;
        push_value_next = push_value_reg;
        instr_next      = instr_reg;

        case (state_reg)
            S_SELECT: begin
                en_next = '0;
                if (pick_valid) begin
                    cur_next    = pick_idx;
                    en_next     = pick_onehot;
                    qcnt_next   = '0;
                    mem_rd_next = 1'b1;
                    state_next  = S_FETCH;
                end
            end
            S_FETCH: state_next = S_DATA;
            S_DATA: begin
                // Decode here so the strobes are registered into S_DISPATCH.
                step_next  = 1'b1;
                yield_next = (mem_data[15:14] == W_YIELD);
                case (mem_data[15:14])
                    W_INSTR: begin
                        instr_next    = mem_data[LIT_W-1:0];
                        instr_en_next = 1'b1;
                    end
                    W_LIT: begin
                        push_value_next = lit_extend(mem_data[LIT_W-1:0]);
                        push_en_next    = 1'b1;
                    end
                    W_RSVD: begin
                        instr_next    = '0;
                        instr_en_next = 1'b1;
                    end
                    default: ;
                endcase
                state_next = S_DISPATCH;
            end
            S_DISPATCH: begin
                qcnt_next = qcnt_reg + 1'b1;
                if (yield_reg) begin
                    en_next    = '0;
                    state_next = S_SELECT;
                end else begin
                    state_next = S_GUARD;
                end
            end
            S_GUARD: state_next = S_WAIT;
            S_WAIT: begin
                if (cur_idle) begin
                    if (quantum_done || !run || !cur_exec) begin
                        en_next    = '0;
                        state_next = S_SELECT;
                    end else begin
                        mem_rd_next = 1'b1;
                        state_next  = S_FETCH;
                    end
                end else if (wd_timeout) begin
                    en_next    = '0;
                    state_next = S_SELECT;
                end
            end
            default: begin
                en_next    = '0;
                state_next = S_SELECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_SELECT;
            cur_reg        <= IW'(CORES-1);
            en_reg         <= '0;
            qcnt_reg       <= '0;
            mem_rd_reg     <= 1'b0;
            push_en_reg    <= 1'b0;
            instr_en_reg   <= 1'b0;
            step_reg       <= 1'b0;
            yield_reg      <= 1'b0;
            push_value_reg <= '0;
            instr_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            cur_reg        <= cur_next;
            en_reg         <= en_next;
            qcnt_reg       <= qcnt_next;
            mem_rd_reg     <= mem_rd_next;
            push_en_reg    <= push_en_next;
            instr_en_reg   <= instr_en_next;
            step_reg       <= step_next;
            yield_reg      <= yield_next;
            push_value_reg <= push_value_next;
            instr_reg      <= instr_next;
        end
    end

    assign core_en     = en_reg;
    assign mem_addr    = pcp_arr[cur_reg];
    assign mem_rd      = mem_rd_reg;
    assign push_value  = push_value_reg;
    assign push_en     = push_en_reg;
    assign instr       = instr_reg;
    assign instr_en    = instr_en_reg;
    assign pcp_step_en = step_reg;
    assign cur_core    = cur_reg;
    assign busy        = (state_reg != S_SELECT);

endmodule
